// File: rtl/mips_mc_pkg.sv
// Shared constants and types for the multicycle MIPS control FSM.
// The optional illegal-opcode trap is enabled by defining MIPS_MC_ILLEGAL_TRAP_EN.
package mips_mc_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned CNT_W   = 32;

  // State encodings
  localparam logic [STATE_W-1:0] FETCH   = STATE_W'(0);
  localparam logic [STATE_W-1:0] DECODE  = STATE_W'(1);
  localparam logic [STATE_W-1:0] MEMADR  = STATE_W'(2);
  localparam logic [STATE_W-1:0] MEMRD   = STATE_W'(3);
  localparam logic [STATE_W-1:0] MEMWB   = STATE_W'(4);
  localparam logic [STATE_W-1:0] MEMWR   = STATE_W'(5);
  localparam logic [STATE_W-1:0] EXECUTE = STATE_W'(6);
  localparam logic [STATE_W-1:0] ALUWB   = STATE_W'(7);
  localparam logic [STATE_W-1:0] BRANCH  = STATE_W'(8);
  localparam logic [STATE_W-1:0] ADDIEX  = STATE_W'(9);
  localparam logic [STATE_W-1:0] ADDIWB  = STATE_W'(10);
  localparam logic [STATE_W-1:0] JUMP    = STATE_W'(11);
  localparam logic [STATE_W-1:0] TRAP    = STATE_W'(12);

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation select
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Raw per-state control vector, before ready gating and reset forcing
  typedef struct packed {
    logic       mem_req;
    logic       mem_w;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       reg_w;
    logic       reg_dest;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Controller <-> datapath/memory signal bundle.
// illegal_op exists only when MIPS_MC_ILLEGAL_TRAP_EN is defined.
interface mips_mc_ctrl_if;
  import mips_mc_pkg::*;

  logic [5:0]         op_code;
  logic               zero;
  logic               mem_ready;
  logic               mem_req;
  logic               mem_w;
  logic               iord;
  logic               ir_write;
  logic               pc_write;
  logic               branch;
  logic               pc_en;
  logic               reg_w;
  logic               reg_dest;
  logic               mem_to_reg;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [1:0]         pc_src;
  logic [STATE_W-1:0] state;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
  logic               illegal_op;
`endif

  // Controller side
  modport master (
    input  op_code, zero, mem_ready,
    output mem_req, mem_w, iord, ir_write, pc_write, branch, pc_en,
           reg_w, reg_dest, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           pc_src, state
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    , output illegal_op
`endif
  );

  // Datapath / memory side
  modport slave (
    output op_code, zero, mem_ready,
    input  mem_req, mem_w, iord, ir_write, pc_write, branch, pc_en,
           reg_w, reg_dest, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           pc_src, state
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    , input illegal_op
`endif
  );

endinterface

// File: rtl/mips_mc_out_dec.sv
// Moore output decoder: state -> raw control vector.
module mips_mc_out_dec
  import mips_mc_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  output ctrl_t              ctrl
);

  // Per-state control assertions; anything not listed stays 0
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PCSRC_ALU;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_w      = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_w   = 1'b1;
        ctrl.iord    = 1'b1;
      end
      EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ALUWB: begin
        ctrl.reg_w    = 1'b1;
        ctrl.reg_dest = 1'b1;
      end
      ADDIWB: begin
        ctrl.reg_w = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with memory-ready stalls.
// Define MIPS_MC_ILLEGAL_TRAP_EN to trap unknown opcodes in TRAP with illegal_op.
module mips_mc_ctrl
  import mips_mc_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mips_mc_ctrl_if.master bus
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  ctrl_t              dec_c;
  logic               fetch_gate_c;
  logic               ir_write_c;
  logic               pc_write_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.op_code)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_ADDI:      state_d = ADDIEX;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
          default:      state_d = TRAP;
`else
          default:      state_d = FETCH;
`endif
        endcase
      end
      MEMADR:  state_d = (bus.op_code == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR:   state_d = bus.mem_ready ? FETCH : MEMWR;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
      TRAP:    state_d = TRAP;
`endif
      default: state_d = FETCH;
    endcase
  end

  mips_mc_out_dec u_out_dec (
    .state (state_q),
    .ctrl  (dec_c)
  );

  // IR/PC loads in FETCH complete only with the memory handshake
  assign fetch_gate_c = (state_q != FETCH) | bus.mem_ready;
  assign ir_write_c   = dec_c.ir_write & fetch_gate_c & ~rst;
  assign pc_write_c   = dec_c.pc_write & fetch_gate_c & ~rst;

  // Strobes forced low during reset; selects follow the decoded state
  assign bus.mem_req    = dec_c.mem_req & ~rst;
  assign bus.mem_w      = dec_c.mem_w & ~rst;
  assign bus.ir_write   = ir_write_c;
  assign bus.pc_write   = pc_write_c;
  assign bus.branch     = dec_c.branch & ~rst;
  assign bus.pc_en      = pc_write_c | (dec_c.branch & bus.zero & ~rst);
  assign bus.reg_w      = dec_c.reg_w & ~rst;
  assign bus.iord       = dec_c.iord;
  assign bus.reg_dest   = dec_c.reg_dest;
  assign bus.mem_to_reg = dec_c.mem_to_reg;
  assign bus.alu_src_a  = dec_c.alu_src_a;
  assign bus.alu_src_b  = dec_c.alu_src_b;
  assign bus.alu_op     = dec_c.alu_op;
  assign bus.pc_src     = dec_c.pc_src;
  assign bus.state      = state_q;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
  assign bus.illegal_op = (state_q == TRAP);
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl; honours MIPS_MC_ILLEGAL_TRAP_EN.
module tb_mips_mc_ctrl;
  import mips_mc_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [20:0] exp_q[$];

  mips_mc_ctrl_if bus ();

  mips_mc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference control vector written from the state table
  function automatic logic [20:0] model(input logic [3:0] s, input logic mr,
                                        input logic z, input logic r);
    logic mreq, mw, io, irw, pcw, br, pce, rw, rd, m2r, sa;
    logic [1:0] sb, ao, ps;
    {mreq, mw, io, irw, pcw, br, rw, rd, m2r, sa} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (s)
      4'd0:  begin mreq = 1; sb = 2'b01; irw = mr; pcw = mr; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mreq = 1; io = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mreq = 1; mw = 1; io = 1; end
      4'd6:  begin sa = 1; ao = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
      4'd9:  begin sa = 1; sb = 2'b10; end
      4'd10: rw = 1;
      4'd11: begin pcw = 1; ps = 2'b10; end
      default: ;
    endcase
    pce = pcw | (br & z);
    if (r) {mreq, mw, irw, pcw, br, pce, rw} = '0;
    return {s, mreq, mw, io, irw, pcw, br, pce, rw, rd, m2r, sa, sb, ao, ps};
  endfunction

  function automatic logic [20:0] obs();
    return {bus.state, bus.mem_req, bus.mem_w, bus.iord, bus.ir_write,
            bus.pc_write, bus.branch, bus.pc_en, bus.reg_w, bus.reg_dest,
            bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src};
  endfunction

  // One clock: push expectation, compare at negedge, advance past posedge
  task automatic cycle(input string name, input logic [3:0] st);
    logic [20:0] exp_v;
    logic [20:0] got;
    exp_q.push_back(model(st, bus.mem_ready, bus.zero, rst));
    @(negedge clk);
    exp_v = exp_q.pop_front();
    got   = obs();
    tests++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL %s st=%0d: got %h expected %h", name, st, got, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name, input logic [3:0] exp_s);
    tests++;
    if (bus.state !== exp_s) begin
      fails++;
      $display("FAIL %s: state got %0d expected %0d", name, bus.state, exp_s);
    end
  endtask

  // Walk a state sequence; handshake states get the requested wait cycles
  task automatic run_seq(input string name, input logic [5:0] op, input logic z,
                         input logic [23:0] seqv, input int n, input int fw,
                         input int mw, input logic [3:0] final_s);
    logic [3:0] st;
    int w;
    bus.op_code = op;
    bus.zero    = z;
    for (int i = 0; i < n; i++) begin
      st = seqv[4*i +: 4];
      w  = (st == 4'd0) ? fw : ((st == 4'd3 || st == 4'd5) ? mw : 0);
      for (int k = 0; k < w; k++) begin
        bus.mem_ready = 1'b0;
        cycle(name, st);
      end
      bus.mem_ready = 1'b1;
      cycle(name, st);
    end
    check_state({name, "_end"}, final_s);
  endtask

  task automatic test_reset();
    bus.mem_ready = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle("reset_hold", 4'd0);
    rst = 1'b0;
  endtask

  task automatic test_lw();
    run_seq("lw", OP_LW, 1'b0, 24'h043210, 5, 0, 0, 4'd0);
  endtask

  task automatic test_sw_wait();
    run_seq("sw_wait", OP_SW, 1'b0, 24'h005210, 4, 0, 2, 4'd0);
  endtask

  task automatic test_rtype_addi();
    run_seq("rtype", OP_RTYPE, 1'b0, 24'h007610, 4, 0, 0, 4'd0);
    run_seq("addi", OP_ADDI, 1'b1, 24'h00A910, 4, 0, 0, 4'd0);
  endtask

  task automatic test_beq();
    run_seq("beq_taken", OP_BEQ, 1'b1, 24'h000810, 3, 0, 0, 4'd0);
    run_seq("beq_not", OP_BEQ, 1'b0, 24'h000810, 3, 0, 0, 4'd0);
  endtask

  task automatic test_jump();
    run_seq("jump", OP_J, 1'b0, 24'h000B10, 3, 0, 0, 4'd0);
  endtask

  task automatic test_fetch_wait();
    run_seq("fetch_wait", OP_J, 1'b0, 24'h000B10, 3, 4, 0, 4'd0);
  endtask

  task automatic test_rst_mid_memrd();
    bus.op_code = OP_LW;
    bus.zero    = 1'b0;
    bus.mem_ready = 1'b1;
    cycle("rst_mid", 4'd0);
    cycle("rst_mid", 4'd1);
    cycle("rst_mid", 4'd2);
    bus.mem_ready = 1'b0;
    cycle("rst_mid", 4'd3);
    rst = 1'b1;
    #1;
    exp_q.push_back(model(4'd0, 1'b0, 1'b0, 1'b1));
    tests++;
    if (obs() !== exp_q[0]) begin
      fails++;
      $display("FAIL rst_mid_async: got %h expected %h", obs(), exp_q[0]);
    end
    void'(exp_q.pop_front());
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_seq("after_rst", OP_J, 1'b0, 24'h000B10, 3, 0, 0, 4'd0);
  endtask

  task automatic test_illegal();
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    run_seq("illegal", 6'b111111, 1'b0, 24'h000010, 2, 0, 0, 4'd12);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (bus.illegal_op !== 1'b1) begin
        fails++;
        $display("FAIL illegal_op: got %b expected 1", bus.illegal_op);
      end
      cycle("trap_hold", 4'd12);
    end
    rst = 1'b1;
    #1;
    check_state("trap_rst", 4'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_seq("after_trap", OP_J, 1'b0, 24'h000B10, 3, 0, 0, 4'd0);
`else
    run_seq("illegal", 6'b111111, 1'b0, 24'h000010, 2, 0, 0, 4'd0);
    run_seq("after_illegal", OP_RTYPE, 1'b0, 24'h007610, 4, 0, 0, 4'd0);
`endif
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    tests = 0;
    fails = 0;
    bus.op_code   = 6'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    test_reset();
    test_lw();
    test_sw_wait();
    test_rtype_addi();
    test_beq();
    test_jump();
    test_fetch_wait();
    test_rst_mid_memrd();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
